// File: rtl/log_hdr_rd_arb.sv
// Two-requester round-robin arbiter for the log header memory read port.
// An in-order owner FIFO steers each memory response back to the requester that issued it.

package log_hdr_rd_arb_pkg;
  localparam int LOG_HDR_DEPTH_W = 8;
  localparam int LOG_ENTRY_HDR_W = 32;
endpackage

module log_hdr_rd_arb
  import log_hdr_rd_arb_pkg::*;
#(
  parameter int OUTSTANDING   = 4,
  parameter int OUTSTANDING_W = $clog2(OUTSTANDING)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_rd_req_val,
  input  logic [LOG_HDR_DEPTH_W-1:0] req0_rd_req_addr,
  output logic                       req0_rd_req_rdy,
  output logic                       req0_rd_resp_val,
  output logic [LOG_ENTRY_HDR_W-1:0] req0_rd_resp_data,
  input  logic                       req0_rd_resp_rdy,
  input  logic                       req1_rd_req_val,
  input  logic [LOG_HDR_DEPTH_W-1:0] req1_rd_req_addr,
  output logic                       req1_rd_req_rdy,
  output logic                       req1_rd_resp_val,
  output logic [LOG_ENTRY_HDR_W-1:0] req1_rd_resp_data,
  input  logic                       req1_rd_resp_rdy,
  output logic                       arb_log_hdr_mem_rd_req_val,
  output logic [LOG_HDR_DEPTH_W-1:0] arb_log_hdr_mem_rd_req_addr,
  input  logic                       log_hdr_mem_arb_rd_req_rdy,
  input  logic                       log_hdr_mem_arb_rd_resp_val,
  input  logic [LOG_ENTRY_HDR_W-1:0] log_hdr_mem_arb_rd_resp_data,
  output logic                       arb_log_hdr_mem_rd_resp_rdy,
  output logic                       arb_idle,
  output logic                       arb_err_unexp_resp
);

  localparam logic [OUTSTANDING_W:0]   FULL_CNT = (OUTSTANDING_W + 1)'(OUTSTANDING);
  localparam logic [OUTSTANDING_W:0]   CNT_ONE  = (OUTSTANDING_W + 1)'(1);
  localparam logic [OUTSTANDING_W-1:0] PTR_ONE  = OUTSTANDING_W'(1);

  logic                     rr_ptr_q, rr_ptr_d;
  logic [OUTSTANDING-1:0]   owner_q, owner_d;
  logic [OUTSTANDING_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OUTSTANDING_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUTSTANDING_W:0]   count_q, count_d;
  logic                     err_q, err_d;

  logic full_s, empty_s, grant_s, req_hs_s, resp_hs_s, head_s, head_rdy_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {(OUTSTANDING_W + 1){1'b0}});

  // Request path: grant uses only registered rr_ptr and current valids, never any rdy.
  always_comb begin
    if (req0_rd_req_val && req1_rd_req_val) begin
      grant_s = rr_ptr_q;
    end else begin
      grant_s = req1_rd_req_val;
    end
    arb_log_hdr_mem_rd_req_val  = rst & (req0_rd_req_val | req1_rd_req_val) & ~full_s;
    arb_log_hdr_mem_rd_req_addr = grant_s ? req1_rd_req_addr : req0_rd_req_addr;
    req0_rd_req_rdy = rst & log_hdr_mem_arb_rd_req_rdy & ~full_s & req0_rd_req_val & ~grant_s;
    req1_rd_req_rdy = rst & log_hdr_mem_arb_rd_req_rdy & ~full_s & req1_rd_req_val & grant_s;
    req_hs_s        = arb_log_hdr_mem_rd_req_val & log_hdr_mem_arb_rd_req_rdy;
  end

  // Response path: data is broadcast, only the FIFO head owner sees valid.
  always_comb begin
    head_s                      = owner_q[rd_ptr_q];
    head_rdy_s                  = head_s ? req1_rd_resp_rdy : req0_rd_resp_rdy;
    req0_rd_resp_val            = rst & log_hdr_mem_arb_rd_resp_val & ~empty_s & ~head_s;
    req1_rd_resp_val            = rst & log_hdr_mem_arb_rd_resp_val & ~empty_s & head_s;
    req0_rd_resp_data           = log_hdr_mem_arb_rd_resp_data;
    req1_rd_resp_data           = log_hdr_mem_arb_rd_resp_data;
    arb_log_hdr_mem_rd_resp_rdy = rst & ~empty_s & head_rdy_s;
    resp_hs_s                   = log_hdr_mem_arb_rd_resp_val & arb_log_hdr_mem_rd_resp_rdy;
  end

  // Next-state: owner FIFO push/pop, round-robin pointer, sticky error.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (req_hs_s) begin
      owner_d[wr_ptr_q] = grant_s;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
      if (req0_rd_req_val && req1_rd_req_val) begin
        rr_ptr_d = ~grant_s;
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (resp_hs_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({req_hs_s, resp_hs_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (log_hdr_mem_arb_rd_resp_val && empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; reset discards every outstanding owner entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 1'b0;
      owner_q  <= {OUTSTANDING{1'b0}};
      wr_ptr_q <= {OUTSTANDING_W{1'b0}};
      rd_ptr_q <= {OUTSTANDING_W{1'b0}};
      count_q  <= {(OUTSTANDING_W + 1){1'b0}};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign arb_idle           = empty_s;
  assign arb_err_unexp_resp = err_q;

endmodule

// File: doc/log_hdr_rd_arb.md
Name: log_hdr_rd_arb

Overview:
- Shares the single log header memory read port between two requesters.
  - Requester 0: the prepare-engine log clean controller.
  - Requester 1: the commit/state-transfer engine.
- Round-robin arbitration on the request path.
- Requester IDs of outstanding reads are held in an in-order owner FIFO, which steers each memory response back to its requester.
- Sits between the engines and the log header memory read interface.

Parameters:
- LOG_HDR_DEPTH_W, package value, log header memory address width.
- OUTSTANDING, 4, maximum reads in flight; power of two, ≥2.
- OUTSTANDING_W, $clog2(OUTSTANDING), FIFO pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req0_rd_req_val  in  1  requester 0 read request valid
- req0_rd_req_addr  in  LOG_HDR_DEPTH_W  requester 0 address
- req0_rd_req_rdy  out  1  requester 0 request accepted
- req0_rd_resp_val  out  1  response valid to requester 0
- req0_rd_resp_data  out  log_entry_hdr  response data to requester 0
- req0_rd_resp_rdy  in  1  requester 0 ready for response
- req1_rd_req_val / req1_rd_req_addr / req1_rd_req_rdy / req1_rd_resp_val / req1_rd_resp_data / req1_rd_resp_rdy  same as requester 0, for requester 1
- arb_log_hdr_mem_rd_req_val  out  1  memory read request valid
- arb_log_hdr_mem_rd_req_addr  out  LOG_HDR_DEPTH_W  memory read address
- log_hdr_mem_arb_rd_req_rdy  in  1  memory accepts request
- log_hdr_mem_arb_rd_resp_val  in  1  memory response valid
- log_hdr_mem_arb_rd_resp_data  in  log_entry_hdr  memory response data
- arb_log_hdr_mem_rd_resp_rdy  out  1  arbiter accepts response
- arb_idle  out  1  no reads outstanding
- arb_err_unexp_resp  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Reset: clk single domain; rst asynchronous, active-low.
  - While rst=0: all *_val and *_rdy outputs forced 0, arb_idle=1, arb_err_unexp_resp=0.
  - Registers cleared: rr_ptr=0, FIFO wr_ptr=rd_ptr=0, count=0, err=0.
  - Reset mid-transaction discards all outstanding owner entries; responses then arriving set the error flag.
- Request path is combinational, zero added latency.
  - full = (count==OUTSTANDING).
  - Grant g: if both valid, g = rr_ptr; else whichever is valid.
  - arb_log_hdr_mem_rd_req_val = (req0_val | req1_val) & ~full.
  - addr = address of requester g.
  - reqg_rd_req_rdy = log_hdr_mem_arb_rd_req_rdy & ~full & (granted). Non-granted requester's rdy=0.
  - Grant depends only on registered rr_ptr and current vals; it never depends on any rdy (no combinational loop).
- Round robin:
  - On a request handshake with both requesters valid, rr_ptr <= ~g.
  - A handshake with a single requester leaves rr_ptr unchanged.
  - A requester that holds val without acceptance keeps its grant claim; val/addr must be stable until rdy (AXI-style).
- Owner FIFO: OUTSTANDING x 1 bit.
  - Push g on request handshake.
  - Pop on response handshake.
  - count updates +1/-1/0; simultaneous push and pop leaves count unchanged.
  - full blocks push even if a pop occurs the same cycle.
  - Pointers wrap modulo OUTSTANDING.
- Response path is combinational.
  - head = owner at rd_ptr; empty = (count==0).
  - req{head}_rd_resp_val = log_hdr_mem_arb_rd_resp_val & ~empty.
  - Data is broadcast to both requesters; only the owner sees val.
  - arb_log_hdr_mem_rd_resp_rdy = ~empty & req{head}_rd_resp_rdy.
  - Responses are strictly in issue order (memory returns in order).
- Unexpected response: log_hdr_mem_arb_rd_resp_val=1 while empty.
  - resp_rdy stays 0 (memory stalls).
  - arb_err_unexp_resp <= 1, cleared only by reset.
- arb_idle = empty.

Test Plan:
- Reset asserted low mid-burst with 3 reads outstanding -> all val/rdy outputs 0 immediately (async); after release arb_idle=1 and count=0.
- Only req0 valid, addr 0x05, memory rdy=1 -> same-cycle mem req addr 0x05 with req0_rdy=1; response 1 cycle later delivered to req0 only; req1_resp_val=0; rr_ptr stays 0.
- Both requesters continuously valid (addrs 0x10/0x20), memory always ready -> grants alternate 0,1,0,1…; response order matches: owner sequence 0,1,0,1.
- Memory withholds responses, 5 back-to-back requests -> 4 accepted, 5th stalled (rdy=0 while full); one response handshake -> 5th accepted the following cycle, not the same cycle.
- Response for req1 at FIFO head with req1_resp_rdy=0 for 3 cycles -> arb_log_hdr_mem_rd_resp_rdy=0 for 3 cycles, data held; a req0 response queued behind it is not delivered early.
- Memory asserts resp_val with FIFO empty -> resp_rdy=0, arb_err_unexp_resp=1 next cycle and stays 1 until reset.
